// File: rtl/endec_scheduler_pkg.sv
// Types and widths shared by the endec scheduler and its arbiter.
package endec_scheduler_pkg;

`ifndef PARAM_DEF_SV
`include "param_def.sv"
`endif

    localparam int JOB_W     = `JOB_W;
    localparam int RES_W     = `RES_W;
    localparam int ENC_RES_W = `ENC_RES_W;
    localparam int DEC_RES_W = `DEC_RES_W;

    // Job lifecycle of the shared core.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_RUN    = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

endpackage

// File: rtl/param_def.sv
// Shared job/result widths and job field offsets for the endec datapath.
`ifndef PARAM_DEF_SV
`define PARAM_DEF_SV

`define JOB_W            640
`define RES_W            704
`define ENC_RES_W        576
`define DEC_RES_W        128

`define JOB_GEN_POLY_LSB 0
`define JOB_GEN_POLY_W   27
`define JOB_RATE_BIT     27
`define JOB_STATE_LSB    28
`define JOB_STATE_W      8
`define JOB_ENC_LSB      64
`define JOB_ENC_W        192
`define JOB_DEC_LSB      256
`define JOB_DEC_W        384

`endif

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester above ptr, wrapping to 0.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_id
);

    logic [N-1:0] gnt_hi;
    logic [N-1:0] gnt_lo;
    logic [W-1:0] id_hi;
    logic [W-1:0] id_lo;

    // Lowest requester above ptr wins; otherwise lowest requester at or below ptr.
    always_comb begin
        // NOTE: every variable gets a default before any condition, so no path infers a latch.
        gnt_hi = '0;
        gnt_lo = '0;
        id_hi  = '0;
        id_lo  = '0;
        gnt    = '0;
        gnt_id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(ptr))) begin
                gnt_hi    = '0;
                gnt_hi[i] = 1'b1;
                id_hi     = W'(i);
            end
            if (req[i] && (i <= int'(ptr))) begin
                gnt_lo    = '0;
                gnt_lo[i] = 1'b1;
                id_lo     = W'(i);
            end
        end
        if (|gnt_hi) begin
            gnt    = gnt_hi;
            gnt_id = id_hi;
        end else begin
            gnt    = gnt_lo;
            gnt_id = id_lo;
        end
    end

endmodule

// File: rtl/endec_scheduler.sv
// Shares one endec core among NUM_CH requesters: grant, clear, run, return result.
module endec_scheduler
    import endec_scheduler_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH*JOB_W-1:0]  req_data,
    output logic                     core_rst_n,
    output logic                     core_en,
    output logic [JOB_W-1:0]         core_job,
    input  logic                     core_enc_done,
    input  logic                     core_dec_done,
    input  logic [ENC_RES_W-1:0]     core_enc_data,
    input  logic [DEC_RES_W-1:0]     core_dec_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [RES_W-1:0]         res_data,
    output logic [CH_W-1:0]          res_ch,
    output logic                     res_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    state_t            state;
    state_t            state_nxt;
    logic [CH_W-1:0]   ptr;
    logic [CNT_W-1:0]  cnt;
    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_id;
    logic [JOB_W-1:0]  job_sel;
    logic              both_done;
    logic              timeout_hit;

    rr_arbiter #(
        .N (NUM_CH),
        .W (CH_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign both_done   = core_enc_done & core_dec_done;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Select the granted channel's job from the flattened request bus.
    always_comb begin
        job_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) job_sel = req_data[i*JOB_W +: JOB_W];
        end
    end

    // Next-state decode and per-state core/handshake outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        core_rst_n = 1'b0;
        core_en    = 1'b0;
        res_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rst) req_ready = gnt;
                if (|req_valid) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                // Hold the core in reset until the previous job's flags have dropped.
                if (!core_enc_done && !core_dec_done) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                core_rst_n = 1'b1;
                core_en    = 1'b1;
                if (both_done || timeout_hit) state_nxt = ST_RESULT;
            end
            ST_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential logic uses <= so every register samples pre-edge values.
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Job/result latches, round-robin pointer and RUN cycle counter.
    always_ff @(posedge sys_clk) begin
        // NOTE: the wide job and result registers are reset too, because they drive outputs.
        if (rst) begin
            core_job <= '0;
            res_data <= '0;
            res_ch   <= '0;
            res_err  <= 1'b0;
            ptr      <= CH_W'(NUM_CH - 1);
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        core_job <= job_sel;
                        res_ch   <= gnt_id;
                    end
                end
                ST_CLEAR: cnt <= '0;
                ST_RUN: begin
                    cnt <= cnt + 1'b1;
                    // Completion takes precedence over a same-cycle timeout.
                    if (both_done) begin
                        res_data <= {core_dec_data, core_enc_data};
                        res_err  <= 1'b0;
                    end else if (timeout_hit) begin
                        res_data <= '0;
                        res_err  <= 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) ptr <= res_ch;
                end
                default: ;
            endcase
        end
    end

endmodule
